cpu_datapath: RTL and testbench

- Combined datapath of the four-CPLD 6502: address-bus-high slice (PCH/ABH), address-bus-low slice (PCL/ABL/SPL/AHL) and ALU slice (A, X, Y, M, ADD).
- Driven cycle by cycle by the external control block over ab_op and the alu_* controls.
- Returns ALU flags to the control block and drives the 16-bit address bus.

---
 rtl/cpu_datapath_if.sv | 27 ++
 rtl/cpu_datapath.sv | 134 +++++++++++++
 tb/tb_cpu_datapath.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Control and bus signals between the 6502 control block and the combined datapath.
interface cpu_datapath_if;
    logic        RDY;
    logic [4:0]  ab_op;
    logic [2:0]  alu_sel;
    logic [2:0]  alu_op;
    logic [2:0]  alu_ld;
    logic        alu_ci;
    logic        tsx;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic [15:0] AB;
    logic        alu_co;
    logic        alu_n;
    logic        alu_z;
    logic        alu_v;

    modport master (
        output RDY, ab_op, alu_sel, alu_op, alu_ld, alu_ci, tsx, DI,
        input  DO, AB, alu_co, alu_n, alu_z, alu_v
    );

    modport slave (
        input  RDY, ab_op, alu_sel, alu_op, alu_ld, alu_ci, tsx, DI,
        output DO, AB, alu_co, alu_n, alu_z, alu_v
    );
endinterface

// File: rtl/cpu_datapath.sv
// 6502 datapath: PC/address-bus slices, stack pointer low byte and the 8-bit ALU
// with A/X/Y/M/ADD registers, sequenced cycle by cycle by the external control block.
module cpu_datapath (
    input logic           clk,
    input logic           RST,
    cpu_datapath_if.slave bus
);
    typedef enum logic [4:0] {
        AB_HOLD = 5'd0,  AB_PC   = 5'd1,  AB_PCI  = 5'd2,  AB_ZP   = 5'd3,
        AB_ABS  = 5'd4,  AB_ABSX = 5'd5,  AB_ABSY = 5'd6,  AB_ZPX  = 5'd7,
        AB_STK  = 5'd8,  AB_PUSH = 5'd9,  AB_POP  = 5'd10, AB_JMP  = 5'd11,
        AB_BR   = 5'd12, AB_RSTV = 5'd13, AB_IRQV = 5'd14, AB_INC  = 5'd15,
        AB_LDPC = 5'd16
    } ab_op_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_OR  = 3'd1, OP_AND = 3'd2, OP_EOR  = 3'd3,
        OP_SUB = 3'd4, OP_ROL = 3'd5, OP_ROR = 3'd6, OP_PASS = 3'd7
    } alu_op_e;

    ab_op_e      ab_op;
    alu_op_e     alu_op;

    logic [15:0] pc_q, pc_d, ab_q, ab_d;
    logic [7:0]  spl_q, spl_d, ahl_q;
    logic [7:0]  a_q, x_q, y_q, m_q, add_q;

    logic [7:0]  l, b, res;
    logic [8:0]  sum9;
    logic        co, v;
    logic [15:0] abs_addr;

    assign ab_op    = ab_op_e'(bus.ab_op);
    assign alu_op   = alu_op_e'(bus.alu_op);
    assign abs_addr = {bus.DI, ahl_q};

    // SB as a left operand always reads SPL: the tsx=0 path (result onto SB)
    // would otherwise feed the ALU output back into its own input.
    always_comb begin
        l = '0;
        case (bus.alu_sel)
            3'd0: l = a_q;
            3'd1: l = x_q;
            3'd2: l = y_q;
            3'd3: l = m_q;
            3'd4: l = spl_q;
            3'd5: l = add_q;
            3'd6: l = '0;
            3'd7: l = '1;
            default: l = '0;
        endcase
    end

    always_comb begin
        b    = (alu_op == OP_SUB) ? ~m_q : m_q;
        sum9 = {1'b0, l} + {1'b0, b} + {8'h00, bus.alu_ci};
        res  = sum9[7:0];
        co   = sum9[8];
        v    = (l[7] == b[7]) & (sum9[7] != l[7]);
        case (alu_op)
            OP_ADD, OP_SUB: ;
            OP_OR:   begin res = l | m_q; co = 1'b0; v = 1'b0; end
            OP_AND:  begin res = l & m_q; co = 1'b0; v = 1'b0; end
            OP_EOR:  begin res = l ^ m_q; co = 1'b0; v = 1'b0; end
            OP_ROL:  begin res = {l[6:0], bus.alu_ci}; co = l[7]; v = 1'b0; end
            OP_ROR:  begin res = {bus.alu_ci, l[7:1]}; co = l[0]; v = 1'b0; end
            default: begin res = l; co = bus.alu_ci; v = 1'b0; end
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ab_d  = ab_q;
        spl_d = spl_q;
        case (ab_op)
            AB_PC:   ab_d = pc_q;
            AB_PCI:  begin pc_d = pc_q + 16'd1; ab_d = pc_q + 16'd1; end
            AB_ZP:   ab_d = {8'h00, bus.DI};
            AB_ABS:  ab_d = abs_addr;
            AB_ABSX: ab_d = abs_addr + {8'h00, x_q};
            AB_ABSY: ab_d = abs_addr + {8'h00, y_q};
            AB_ZPX:  ab_d = {8'h00, bus.DI + x_q};
            AB_STK:  ab_d = {8'h01, spl_q};
            AB_PUSH: begin ab_d = {8'h01, spl_q}; spl_d = spl_q - 8'd1; end
            AB_POP:  begin spl_d = spl_q + 8'd1; ab_d = {8'h01, spl_q + 8'd1}; end
            AB_JMP:  begin pc_d = abs_addr; ab_d = abs_addr; end
            AB_BR:   begin
                pc_d = pc_q + {{8{bus.DI[7]}}, bus.DI};
                ab_d = pc_q + {{8{bus.DI[7]}}, bus.DI};
            end
            AB_RSTV: ab_d = 16'hFFFC;
            AB_IRQV: ab_d = 16'hFFFE;
            AB_INC:  ab_d = ab_q + 16'd1;
            AB_LDPC: pc_d = ab_q;
            default: ;
        endcase
        if (bus.alu_ld == 3'd4 && !bus.tsx)
            spl_d = res;
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            pc_q  <= '0;
            ab_q  <= 16'hFFFC;
            spl_q <= '1;
            ahl_q <= '0;
            a_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            m_q   <= '0;
            add_q <= '0;
        end else if (bus.RDY) begin
            pc_q  <= pc_d;
            ab_q  <= ab_d;
            spl_q <= spl_d;
            ahl_q <= bus.DI;
            m_q   <= bus.DI;
            add_q <= res;
            case (bus.alu_ld)
                3'd1: a_q <= res;
                3'd2: x_q <= res;
                3'd3: y_q <= res;
                default: ;
            endcase
        end
    end

    assign bus.DO     = add_q;
    assign bus.AB     = ab_q;
    assign bus.alu_co = co;
    assign bus.alu_n  = res[7];
    assign bus.alu_z  = (res == 8'h00);
    assign bus.alu_v  = v;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: expectations are queued as stimulus is driven
// and popped against AB, DO or the ALU flags once the DUT has produced them.
module tb_cpu_datapath;
    logic clk = 1'b0;
    logic RST;

    cpu_datapath_if bus ();

    cpu_datapath dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    localparam int K_AB = 0, K_DO = 1, K_FL = 2;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic expect_val(input string tag, input int kind, input logic [15:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_AB:    obs = bus.AB;
                K_DO:    obs = {8'h00, bus.DO};
                default: obs = {12'h000, bus.alu_co, bus.alu_n, bus.alu_z, bus.alu_v};
            endcase
            tests++;
            assert (obs === e.exp)
            else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] sel, input logic [2:0] aop,
                         input logic [2:0] ld, input logic ci, input logic t, input logic [7:0] di);
        bus.ab_op   = op;
        bus.alu_sel = sel;
        bus.alu_op  = aop;
        bus.alu_ld  = ld;
        bus.alu_ci  = ci;
        bus.tsx     = t;
        bus.DI      = di;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic step(input logic [4:0] op, input logic [2:0] sel, input logic [2:0] aop,
                        input logic [2:0] ld, input logic ci, input logic t, input logic [7:0] di);
        drive(op, sel, aop, ld, ci, t, di);
        tick();
    endtask

    initial begin
        RST     = 1'b0;
        bus.RDY = 1'b1;
        drive(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        #12;
        expect_val("reset_ab", K_AB, 16'hFFFC);
        expect_val("reset_do", K_DO, 16'h0000);
        check_all();
        RST = 1'b1;

        // SPL and A after reset
        expect_val("reset_spl", K_AB, 16'h01FF);
        expect_val("reset_a", K_DO, 16'h0000);
        step(5'd8, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);

        // JMP to 12FF, then PC+1 with RDY low and high
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'hFF);
        expect_val("jmp_12ff", K_AB, 16'h12FF);
        step(5'd11, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h12);
        bus.RDY = 1'b0;
        expect_val("rdy_hold", K_AB, 16'h12FF);
        step(5'd2, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        bus.RDY = 1'b1;
        expect_val("pc_inc_page", K_AB, 16'h1300);
        step(5'd2, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        expect_val("pc_value", K_AB, 16'h1300);
        step(5'd1, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);

        // X=20, AHL=F0, ABSX with DI=20
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h20);
        step(5'd0, 3'd3, 3'd7, 3'd2, 1'b0, 1'b0, 8'hF0);
        expect_val("absx_cross", K_AB, 16'h2110);
        step(5'd5, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h20);

        // Branches backward and forward
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h05);
        expect_val("jmp_1005", K_AB, 16'h1005);
        step(5'd11, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h10);
        expect_val("branch_back", K_AB, 16'h1000);
        step(5'd12, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'hFB);
        expect_val("branch_back_pc", K_AB, 16'h1000);
        step(5'd1, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'hF0);
        step(5'd11, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h10);
        expect_val("branch_fwd", K_AB, 16'h1110);
        step(5'd12, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h20);

        // SPL=00 via X, then push/stk/pop wrap
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        step(5'd0, 3'd3, 3'd7, 3'd2, 1'b0, 1'b0, 8'h00);
        step(5'd0, 3'd1, 3'd7, 3'd4, 1'b0, 1'b0, 8'h00);
        expect_val("push_ab", K_AB, 16'h0100);
        step(5'd9, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        expect_val("push_spl_wrap", K_AB, 16'h01FF);
        step(5'd8, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);
        expect_val("pop_wrap", K_AB, 16'h0100);
        step(5'd10, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);

        // ADD overflow 7F+01
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h7F);
        step(5'd0, 3'd3, 3'd7, 3'd1, 1'b0, 1'b0, 8'h01);
        drive(5'd0, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 8'h00);
        expect_val("add_flags", K_FL, 16'h0005);
        #1 check_all();
        expect_val("add_result", K_DO, 16'h0080);
        tick();

        // SUB 05-05 with carry in
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h05);
        step(5'd0, 3'd3, 3'd7, 3'd1, 1'b0, 1'b0, 8'h05);
        drive(5'd0, 3'd0, 3'd4, 3'd0, 1'b1, 1'b0, 8'h00);
        expect_val("sub_flags", K_FL, 16'h000A);
        #1 check_all();
        expect_val("sub_result", K_DO, 16'h0000);
        tick();

        // TXS with X=3C
        step(5'd0, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h3C);
        step(5'd0, 3'd3, 3'd7, 3'd2, 1'b0, 1'b0, 8'h00);
        step(5'd0, 3'd1, 3'd7, 3'd4, 1'b0, 1'b0, 8'h00);
        expect_val("txs_spl", K_AB, 16'h013C);
        step(5'd8, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);

        expect_val("irq_vector", K_AB, 16'hFFFE);
        step(5'd14, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);

        // ROL of FF with ci=0
        drive(5'd0, 3'd7, 3'd5, 3'd0, 1'b0, 1'b0, 8'hE0);
        expect_val("rol_flags", K_FL, 16'h000C);
        #1 check_all();
        expect_val("rol_result", K_DO, 16'h00FE);
        tick();

        // ZPX wraps in the low byte: E0+3C
        expect_val("zpx_wrap", K_AB, 16'h001C);
        step(5'd7, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'hE0);
        expect_val("ab_inc", K_AB, 16'h001D);
        step(5'd15, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
